// File: rtl/hmcad_reg_arbiter_if.sv
// Requester-side and SPI-transceiver-side signals of the HMCAD register-write arbiter.
// The arbiter connects through the slave modport; the requesters and transceiver use master.
interface hmcad_reg_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [8*NUM_REQ-1:0]  req_addr;
   logic [16*NUM_REQ-1:0] req_value;
   logic [NUM_REQ-1:0]    req_done;
   logic [NUM_REQ-1:0]    req_err;
   logic                  busy;
   logic                  shift_en;
   logic [7:0]            tx_data;
   logic                  shift_done;
   logic                  spi_cs_n;

   modport slave (
      input  req_valid,
      input  req_addr,
      input  req_value,
      input  shift_done,
      output req_done,
      output req_err,
      output busy,
      output shift_en,
      output tx_data,
      output spi_cs_n
   );

   modport master (
      output req_valid,
      output req_addr,
      output req_value,
      output shift_done,
      input  req_done,
      input  req_err,
      input  busy,
      input  shift_en,
      input  tx_data,
      input  spi_cs_n
   );
endinterface

// File: rtl/hmcad_reg_arbiter.sv
// Round-robin arbiter that serialises 8-bit-address / 16-bit-value register writes
// from several requesters onto one byte-wide SPI transceiver driving the ADC.
module hmcad_reg_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int CS_GAP  = 8,
   parameter int TIMEOUT = 4095
) (
   input  logic               clk,
   input  logic               rst,
   hmcad_reg_arbiter_if.slave bus
);
   localparam int PTR_W  = $clog2(NUM_REQ);
   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(NUM_REQ - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [7:0]        GAP_LOAD  = 8'(CS_GAP);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ADDR,
      HI,
      LO,
      GAP
   } state_t;

   state_t               state_reg,    state_next;
   logic [PTR_W-1:0]     rr_ptr_reg,   rr_ptr_next;
   logic [PTR_W-1:0]     grant_reg,    grant_next;
   logic [7:0]           addr_reg,     addr_next;
   logic [15:0]          value_reg,    value_next;
   logic [WAIT_W-1:0]    wait_cnt_reg, wait_cnt_next;
   logic [7:0]           gap_cnt_reg,  gap_cnt_next;
   logic                 cs_n_reg,     cs_n_next;
   logic                 shift_en_reg, shift_en_next;
   logic [7:0]           tx_data_reg,  tx_data_next;
   logic [NUM_REQ-1:0]   done_reg,     done_next;
   logic [NUM_REQ-1:0]   err_reg,      err_next;
   logic                 end_xfer;

   logic [7:0]           addr_arr  [NUM_REQ];
   logic [15:0]          value_arr [NUM_REQ];
   logic [PTR_W-1:0]     rot_idx   [NUM_REQ];
   logic [NUM_REQ-1:0]   rot_valid;
   logic [PTR_W-1:0]     sel_idx;
   logic                 any_valid;

   // Slot gi of the rotated view is requester (rr_ptr + gi) mod NUM_REQ.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
         logic [PTR_W:0] rot_sum;

         assign addr_arr[gi]  = bus.req_addr[8*gi +: 8];
         assign value_arr[gi] = bus.req_value[16*gi +: 16];
         assign rot_sum       = {1'b0, rr_ptr_reg} + (PTR_W+1)'(gi);
         assign rot_idx[gi]   = (rot_sum >= (PTR_W+1)'(NUM_REQ))
                                ? PTR_W'(rot_sum - (PTR_W+1)'(NUM_REQ))
                                : rot_sum[PTR_W-1:0];
         assign rot_valid[gi] = bus.req_valid[rot_idx[gi]];
      end
   endgenerate

   assign any_valid = |bus.req_valid;

   always_comb begin
      sel_idx = rr_ptr_reg;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot_valid[i]) begin
            sel_idx = rot_idx[i];
         end
      end
   end

   always_comb begin
      state_next    = state_reg;
      rr_ptr_next   = rr_ptr_reg;
      grant_next    = grant_reg;
      addr_next     = addr_reg;
      value_next    = value_reg;
      wait_cnt_next = wait_cnt_reg;
      gap_cnt_next  = gap_cnt_reg;
      cs_n_next     = cs_n_reg;
      shift_en_next = 1'b0;
      tx_data_next  = tx_data_reg;
      done_next     = '0;
      err_next      = '0;
      end_xfer      = 1'b0;

      case (state_reg)
         IDLE: begin
            if (any_valid) begin
               grant_next = sel_idx;
               addr_next  = addr_arr[sel_idx];
               value_next = value_arr[sel_idx];
               cs_n_next  = 1'b0;
               state_next = SETUP;
            end
         end

         SETUP: begin
            shift_en_next = 1'b1;
            tx_data_next  = addr_reg;
            wait_cnt_next = '0;
            state_next    = ADDR;
         end

         ADDR, HI, LO: begin
            if (bus.shift_done) begin
               wait_cnt_next = '0;
               if (state_reg == ADDR) begin
                  shift_en_next = 1'b1;
                  tx_data_next  = value_reg[15:8];
                  state_next    = HI;
               end else if (state_reg == HI) begin
                  shift_en_next = 1'b1;
                  tx_data_next  = value_reg[7:0];
                  state_next    = LO;
               end else begin
                  end_xfer             = 1'b1;
                  done_next[grant_reg] = 1'b1;
               end
            end else if (wait_cnt_reg == WAIT_LAST) begin
               // The edge that would bring the count to TIMEOUT aborts the write.
               end_xfer            = 1'b1;
               err_next[grant_reg] = 1'b1;
            end else begin
               wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
            end

            if (end_xfer) begin
               cs_n_next    = 1'b1;
               rr_ptr_next  = (grant_reg == LAST_IDX) ? '0 : grant_reg + PTR_W'(1);
               gap_cnt_next = GAP_LOAD;
               // A zero gap skips GAP so chip select is high only for the IDLE cycle.
               state_next   = (CS_GAP == 0) ? IDLE : GAP;
            end
         end

         GAP: begin
            if (gap_cnt_reg <= 8'd1) begin
               state_next = IDLE;
            end else begin
               gap_cnt_next = gap_cnt_reg - 8'd1;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         rr_ptr_reg   <= '0;
         grant_reg    <= '0;
         addr_reg     <= '0;
         value_reg    <= '0;
         wait_cnt_reg <= '0;
         gap_cnt_reg  <= '0;
         cs_n_reg     <= 1'b1;
         shift_en_reg <= 1'b0;
         tx_data_reg  <= '0;
         done_reg     <= '0;
         err_reg      <= '0;
      end else begin
         state_reg    <= state_next;
         rr_ptr_reg   <= rr_ptr_next;
         grant_reg    <= grant_next;
         addr_reg     <= addr_next;
         value_reg    <= value_next;
         wait_cnt_reg <= wait_cnt_next;
         gap_cnt_reg  <= gap_cnt_next;
         cs_n_reg     <= cs_n_next;
         shift_en_reg <= shift_en_next;
         tx_data_reg  <= tx_data_next;
         done_reg     <= done_next;
         err_reg      <= err_next;
      end
   end

   assign bus.req_done = done_reg;
   assign bus.req_err  = err_reg;
   assign bus.busy     = (state_reg != IDLE);
   assign bus.shift_en = shift_en_reg;
   assign bus.tx_data  = tx_data_reg;
   assign bus.spi_cs_n = cs_n_reg;
endmodule

// File: tb/tb_hmcad_reg_arbiter.sv
// Directed bench for hmcad_reg_arbiter: one instance with an 8-cycle chip-select gap,
// one with a zero gap, each driven by a simple byte-transceiver responder.
module tb_hmcad_reg_arbiter;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hmcad_reg_arbiter_if #(.NUM_REQ(N)) bus_a ();
   hmcad_reg_arbiter_if #(.NUM_REQ(N)) bus_b ();

   hmcad_reg_arbiter #(.NUM_REQ(N), .CS_GAP(8), .TIMEOUT(4095)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   hmcad_reg_arbiter #(.NUM_REQ(N), .CS_GAP(0), .TIMEOUT(4095)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor and responder state for the CS_GAP=8 instance.
   logic [7:0] byte_log [256];
   int         byte_cyc [256];
   int         byte_tot = 0;
   int         done_log [64];
   int         done_tot = 0;
   int         err_log [64];
   int         err_tot = 0;
   int         err_cyc_last = 0;
   logic       cs_at_err = 1'b0;
   int         both_tot = 0;
   int         busy_hi_tot = 0;
   int         hi_run = 0;
   int         last_hi_run = 0;
   int         pend_a = 0;
   int         sd_tot_a = 0;
   int         sd_lim_a = 32'h3fff_ffff;

   // Monitor and responder state for the CS_GAP=0 instance.
   logic [7:0] byte_log_b [64];
   int         byte_tot_b = 0;
   int         done_log_b [16];
   int         done_tot_b = 0;
   int         err_tot_b = 0;
   int         busy_tot_b = 0;
   int         hi_run_b = 0;
   int         last_hi_run_b = 0;
   int         pend_b = 0;
   int         spur_tgt_b = 0;
   int         spur_cnt_b = 0;

   int bb, db, eb, bh, bb2;

   always @(negedge clk) begin
      if (bus_a.shift_en) begin
         byte_log[byte_tot % 256] = bus_a.tx_data;
         byte_cyc[byte_tot % 256] = cyc;
         byte_tot++;
      end
      if (|bus_a.req_done) begin
         done_log[done_tot % 64] = int'(bus_a.req_done);
         done_tot++;
      end
      if (|bus_a.req_err) begin
         err_log[err_tot % 64] = int'(bus_a.req_err);
         err_cyc_last = cyc;
         cs_at_err = bus_a.spi_cs_n;
         err_tot++;
      end
      if ((|bus_a.req_done) && (|bus_a.req_err)) both_tot++;
      if (bus_a.busy && bus_a.spi_cs_n) busy_hi_tot++;
      if (bus_a.spi_cs_n) begin
         hi_run++;
      end else begin
         if (hi_run > 0) last_hi_run = hi_run;
         hi_run = 0;
      end
   end

   always @(negedge clk) begin
      bus_a.shift_done = 1'b0;
      if (rst) begin
         pend_a = 0;
      end else begin
         if (pend_a > 0) begin
            pend_a--;
            if (pend_a == 0) bus_a.shift_done = 1'b1;
         end
         if (bus_a.shift_en && sd_tot_a < sd_lim_a) begin
            pend_a = 10;
            sd_tot_a++;
         end
      end
   end

   always @(negedge clk) begin
      if (bus_b.shift_en) begin
         byte_log_b[byte_tot_b % 64] = bus_b.tx_data;
         byte_tot_b++;
      end
      if (|bus_b.req_done) begin
         done_log_b[done_tot_b % 16] = int'(bus_b.req_done);
         done_tot_b++;
      end
      if (|bus_b.req_err) err_tot_b++;
      if (bus_b.busy) busy_tot_b++;
      if (bus_b.spi_cs_n) begin
         hi_run_b++;
      end else begin
         if (hi_run_b > 0) last_hi_run_b = hi_run_b;
         hi_run_b = 0;
      end
   end

   always @(negedge clk) begin
      bus_b.shift_done = 1'b0;
      if (rst) begin
         pend_b = 0;
      end else begin
         if (pend_b > 0) begin
            pend_b--;
            if (pend_b == 0) bus_b.shift_done = 1'b1;
         end
         if (bus_b.shift_en) pend_b = 3;
         if (spur_cnt_b < spur_tgt_b) begin
            bus_b.shift_done = 1'b1;
            spur_cnt_b++;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic int evt_count(input int sel);
      case (sel)
         0:       return done_tot + err_tot;
         1:       return byte_tot;
         2:       return done_tot_b;
         default: return byte_tot_b;
      endcase
   endfunction

   task automatic wait_evt(input int sel, input int target, input int budget, input string tag);
      int n = 0;
      while (evt_count(sel) < target && n < budget) begin
         tick();
         n++;
      end
      if (evt_count(sel) < target) chk(tag, evt_count(sel), target);
   endtask

   task automatic wait_idle(input int sel, input int budget, input string tag);
      int n = 0;
      while (((sel == 0) ? bus_a.busy : bus_b.busy) && n < budget) begin
         tick();
         n++;
      end
      chk(tag, (sel == 0) ? bus_a.busy : bus_b.busy, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic set_req_a(input int i, input logic [7:0] a, input logic [15:0] v);
      bus_a.req_addr[8*i +: 8]   = a;
      bus_a.req_value[16*i +: 16] = v;
   endtask

   task automatic set_req_b(input int i, input logic [7:0] a, input logic [15:0] v);
      bus_b.req_addr[8*i +: 8]   = a;
      bus_b.req_value[16*i +: 16] = v;
   endtask

   initial begin
      logic [3:0]  clr;
      logic [15:0] v;

      bus_a.req_valid = '0;
      bus_a.req_addr  = '0;
      bus_a.req_value = '0;
      bus_b.req_valid = '0;
      bus_b.req_addr  = '0;
      bus_b.req_value = '0;
      repeat (3) tick();

      // Outputs while reset is held.
      chk("rst_cs_n",     bus_a.spi_cs_n, 1);
      chk("rst_shift_en", bus_a.shift_en, 0);
      chk("rst_tx_data",  bus_a.tx_data,  0);
      chk("rst_done",     bus_a.req_done, 0);
      chk("rst_err",      bus_a.req_err,  0);
      chk("rst_busy",     bus_a.busy,     0);
      rst = 1'b0;

      // Single write; inputs change after grant and must not disturb it.
      set_req_a(0, 8'h31, 16'h0001);
      bb = byte_tot; db = done_tot; eb = err_tot; bh = busy_hi_tot;
      bus_a.req_valid = 4'b0001;
      wait_evt(1, bb + 1, 20, "single_first_byte_wait");
      bus_a.req_valid = 4'b0000;
      set_req_a(0, 8'hFF, 16'hFFFF);
      wait_evt(0, db + eb + 1, 200, "single_done_wait");
      wait_idle(0, 50, "single_idle");
      chk("single_b0", byte_log[bb % 256], 8'h31);
      chk("single_b1", byte_log[(bb + 1) % 256], 8'h00);
      chk("single_b2", byte_log[(bb + 2) % 256], 8'h01);
      chk("single_nbytes", byte_tot - bb, 3);
      chk("single_ndone", done_tot - db, 1);
      chk("single_done_vec", done_log[db % 64], 4'b0001);
      chk("single_nerr", err_tot - eb, 0);
      chk("single_gap_cycles", busy_hi_tot - bh, 8);
      $display("txn single grant=0 addr=31 value=0001 bytes=%0d", byte_tot - bb);

      // Contention: all four held, each dropped on its own done.
      do_reset();
      for (int i = 0; i < N; i++) set_req_a(i, 8'h40 + 8'(i), 16'h1111 * 16'(i + 1));
      bb = byte_tot; db = done_tot;
      bus_a.req_valid = 4'b1111;
      for (int k = 0; k < N; k++) begin
         wait_evt(0, db + k + 1, 200, "cont_done_wait");
         if (done_tot > db + k) begin
            clr = 4'(done_log[(db + k) % 64]);
            bus_a.req_valid = bus_a.req_valid & ~clr;
         end
      end
      wait_idle(0, 50, "cont_idle");
      for (int k = 0; k < N; k++) begin
         v = 16'h1111 * 16'(k + 1);
         chk("cont_grant", done_log[(db + k) % 64], 1 << k);
         chk("cont_addr",  byte_log[(bb + 3*k) % 256], 8'h40 + 8'(k));
         chk("cont_hi",    byte_log[(bb + 3*k + 1) % 256], v[15:8]);
         chk("cont_lo",    byte_log[(bb + 3*k + 2) % 256], v[7:0]);
         $display("txn contention k=%0d done=%b", k, done_log[(db + k) % 64]);
      end
      chk("cont_cs_high_between", last_hi_run, 9);
      db = done_tot;
      bus_a.req_valid = 4'b1010;
      wait_evt(0, db + 1, 200, "cont_wrap_wait");
      bus_a.req_valid = 4'b0000;
      chk("cont_rr_ptr_wrapped", done_log[db % 64], 4'b0010);
      wait_idle(0, 50, "cont_wrap_idle");
      $display("txn rr_wrap done=%b", done_log[db % 64]);

      // Fairness: req 2 joins while req 0 is being served and held.
      do_reset();
      bb = byte_tot; db = done_tot;
      bus_a.req_valid = 4'b0001;
      wait_evt(1, bb + 1, 20, "fair_first_byte_wait");
      bus_a.req_valid = 4'b0101;
      wait_evt(0, db + 3, 600, "fair_done_wait");
      bus_a.req_valid = 4'b0000;
      wait_idle(0, 50, "fair_idle");
      chk("fair_first",  done_log[db % 64], 4'b0001);
      chk("fair_second", done_log[(db + 1) % 64], 4'b0100);
      chk("fair_third",  done_log[(db + 2) % 64], 4'b0001);
      $display("txn fairness order=%b,%b,%b", done_log[db % 64],
               done_log[(db + 1) % 64], done_log[(db + 2) % 64]);

      // Timeout: only the address byte is answered.
      do_reset();
      set_req_a(1, 8'h55, 16'hABCD);
      sd_lim_a = sd_tot_a + 1;
      bb = byte_tot; db = done_tot; eb = err_tot;
      bus_a.req_valid = 4'b0010;
      wait_evt(1, bb + 2, 100, "tmo_second_byte_wait");
      bus_a.req_valid = 4'b0000;
      wait_evt(0, db + eb + 1, 5000, "tmo_err_wait");
      sd_lim_a = 32'h3fff_ffff;
      chk("tmo_nerr", err_tot - eb, 1);
      chk("tmo_err_vec", err_log[eb % 64], 4'b0010);
      chk("tmo_ndone", done_tot - db, 0);
      chk("tmo_latency", err_cyc_last - byte_cyc[(bb + 1) % 256], 4095);
      chk("tmo_cs_n", cs_at_err, 1);
      chk("tmo_nbytes", byte_tot - bb, 2);
      chk("tmo_hi_byte", byte_log[(bb + 1) % 256], 8'hAB);
      wait_idle(0, 50, "tmo_idle");
      $display("txn timeout grant=1 latency=%0d", err_cyc_last - byte_cyc[(bb + 1) % 256]);

      // Reset while the high value byte is in flight.
      do_reset();
      set_req_a(0, 8'h21, 16'h3344);
      set_req_a(2, 8'h62, 16'h7788);
      bb = byte_tot;
      bus_a.req_valid = 4'b0001;
      wait_evt(1, bb + 2, 30, "rst_hi_wait");
      repeat (3) tick();
      bus_a.req_valid = 4'b0100;
      db = done_tot; eb = err_tot;
      rst = 1'b1;
      #1;
      chk("midrst_cs_n_async", bus_a.spi_cs_n, 1);
      chk("midrst_busy", bus_a.busy, 0);
      tick();
      tick();
      chk("midrst_no_done", done_tot - db, 0);
      chk("midrst_no_err", err_tot - eb, 0);
      bb2 = byte_tot;
      rst = 1'b0;
      wait_evt(0, db + eb + 1, 200, "midrst_regrant_wait");
      bus_a.req_valid = 4'b0000;
      chk("midrst_first_byte", byte_log[bb2 % 256], 8'h62);
      chk("midrst_grant", done_log[db % 64], 4'b0100);
      wait_idle(0, 50, "midrst_idle");
      $display("txn reset_mid_hi regrant done=%b", done_log[db % 64]);

      // Zero-gap instance: spurious shift_done in IDLE, then two requesters.
      bb = byte_tot_b; bh = busy_tot_b;
      spur_tgt_b = spur_tgt_b + 1;
      repeat (3) tick();
      chk("gap0_spur_no_byte", byte_tot_b - bb, 0);
      chk("gap0_spur_no_busy", busy_tot_b - bh, 0);
      set_req_b(0, 8'h0A, 16'h0102);
      set_req_b(1, 8'h0B, 16'h0304);
      bb = byte_tot_b; db = done_tot_b;
      bus_b.req_valid = 4'b0011;
      wait_evt(2, db + 1, 100, "gap0_first_wait");
      bus_b.req_valid = 4'b0010;
      wait_evt(2, db + 2, 100, "gap0_second_wait");
      bus_b.req_valid = 4'b0000;
      wait_idle(1, 20, "gap0_idle");
      chk("gap0_first",  done_log_b[db % 16], 4'b0001);
      chk("gap0_second", done_log_b[(db + 1) % 16], 4'b0010);
      chk("gap0_b0", byte_log_b[bb % 64], 8'h0A);
      chk("gap0_b3", byte_log_b[(bb + 3) % 64], 8'h0B);
      chk("gap0_b5", byte_log_b[(bb + 5) % 64], 8'h04);
      chk("gap0_cs_high_between", last_hi_run_b, 1);
      chk("gap0_no_err", err_tot_b, 0);
      bb = byte_tot_b; bh = busy_tot_b;
      spur_tgt_b = spur_tgt_b + 1;
      repeat (3) tick();
      chk("gap0_spur2_no_byte", byte_tot_b - bb, 0);
      chk("gap0_spur2_no_busy", busy_tot_b - bh, 0);
      $display("txn gap0 order=%b,%b cs_high=%0d", done_log_b[db % 16],
               done_log_b[(db + 1) % 16], last_hi_run_b);

      chk("never_done_and_err", both_tot, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/hmcad_reg_arbiter.md
HMCAD_REG_ARBITER -- requirements
Module: hmcad_reg_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 4: number of register-write requesters (2..8).
REQ-002 The module SHALL have parameter CS_GAP, default 8: clk cycles spi_cs_n held high between transactions (0..255).
REQ-003 The module SHALL have parameter TIMEOUT, default 4095: max clk cycles waiting for any one shift_done before abort.
REQ-004 The module SHALL have port clk, input, 1: single clock for all logic.
REQ-005 The module SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 The module SHALL have port req_valid, input, NUM_REQ: per-requester write request, level.
REQ-007 The module SHALL have port req_addr, input, 8*NUM_REQ: register address, requester i at bits [8i+7:8i].
REQ-008 The module SHALL have port req_value, input, 16*NUM_REQ: register value, requester i at bits [16i+15:16i].
REQ-009 The module SHALL have port req_done, output, NUM_REQ: one-cycle completion pulse to the granted requester.
REQ-010 The module SHALL have port req_err, output, NUM_REQ: one-cycle timeout-abort pulse to the granted requester.
REQ-011 The module SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-012 The module SHALL have port shift_en, output, 1: one-cycle strobe to the byte SPI transceiver.
REQ-013 The module SHALL have port tx_data, output, 8: byte presented with shift_en.
REQ-014 The module SHALL have port shift_done, input, 1: one-cycle byte-complete pulse from the transceiver.
REQ-015 The module SHALL have port spi_cs_n, output, 1: ADC chip select, active low.

Function
REQ-016 The arbiter SHALL implement states IDLE, SETUP, ADDR, HI, LO, GAP.
REQ-017 In IDLE with any req_valid bit high, the arbiter SHALL grant the lowest index at or after rr_ptr (wrapping modulo NUM_REQ), capture that requester's addr and value, drive spi_cs_n low, and go to SETUP.
REQ-018 In SETUP, the arbiter SHALL pulse shift_en with tx_data = captured addr and go to ADDR.
REQ-019 In ADDR, on shift_done, the arbiter SHALL pulse shift_en with tx_data = value[15:8] and go to HI.
REQ-020 In HI, on shift_done, the arbiter SHALL pulse shift_en with tx_data = value[7:0] and go to LO.
REQ-021 In LO, on shift_done, the arbiter SHALL in the same clock edge drive spi_cs_n high, pulse req_done[grant], set rr_ptr = (grant+1) mod NUM_REQ, load the gap counter with CS_GAP, and go to GAP.
REQ-022 GAP SHALL last exactly CS_GAP cycles, then return to IDLE; with CS_GAP = 0 it SHALL return to IDLE on the next cycle.
REQ-023 The arbiter SHALL grant at most once per IDLE visit, so back-to-back requests are separated by at least CS_GAP+1 cycles of spi_cs_n high.
REQ-024 Captured addr and value SHALL stay stable for the whole transaction regardless of later req_* changes.
REQ-025 If req_valid[grant] deasserts after grant, the transaction SHALL still complete and req_done[grant] SHALL still pulse.
REQ-026 A requester holding req_valid high after req_done SHALL be re-arbitrated normally; round-robin SHALL prevent it starving others.
REQ-027 shift_done SHALL be ignored in IDLE, SETUP and GAP.
REQ-028 A wait counter SHALL clear on every shift_en pulse.
REQ-029 If the wait counter reaches TIMEOUT in ADDR, HI or LO, the arbiter SHALL drive spi_cs_n high, pulse req_err[grant] (not req_done), advance rr_ptr as in REQ-021, and go to GAP.
REQ-030 shift_en, req_done and req_err SHALL each be high for exactly one cycle per event, and req_done and req_err SHALL never assert together.
REQ-031 shift_en SHALL be a registered output with no combinational path from any input.

Reset
REQ-032 While rst is high, outputs SHALL be: spi_cs_n=1, shift_en=0, tx_data=0, req_done=0, req_err=0, busy=0; internally state=IDLE, rr_ptr=0, counters=0.
REQ-033 rst asserted mid-transaction SHALL abort immediately, with spi_cs_n high asynchronously and no req_done or req_err pulse.
REQ-034 After rst deasserts, the first grant SHALL be evaluated on the first clk edge.

Verification
REQ-035 Single write: req_valid=0001, addr 0x31, value 0x0001, shift_done 10 cycles after each shift_en -> tx_data 0x31, 0x00, 0x01; cs_n low throughout; one req_done[0]; cs_n high for 8 cycles.
REQ-036 Contention: req_valid=1111 held, done dropped per grant -> grant order 0,1,2,3; then rr_ptr=0.
REQ-037 Fairness: req 0 held continuously, req 2 raised mid-transaction of req 0 -> next grant is 2, then 0.
REQ-038 Timeout: no shift_done after the second byte, TIMEOUT=4095 -> req_err[grant] 4095 cycles after that shift_en; cs_n high; no req_done.
REQ-039 Reset mid-HI: assert rst -> cs_n=1 asynchronously; busy=0; no done/err; after release, pending req_valid=0100 is granted with addr byte first.
REQ-040 CS_GAP=0, two requesters -> cs_n high for exactly 1 cycle between transactions; spurious shift_done in IDLE ignored.
